// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one block-wide main memory between the icache (read-only)
// and the dcache (read/write), serialising transfers with round-robin tie-breaking.
module mem_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 128
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [DATA_W-1:0] i_readdata,
    output logic              i_busywait,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_writedata,
    output logic [DATA_W-1:0] d_readdata,
    output logic              d_busywait,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_busywait
);
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
    state_t state, next_state;
    logic i_done, d_done, seen_busy, last_grant_d;
    logic i_req, d_req, grant_i, grant_d, complete;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = grant_d ? SERVE_D : grant_i ? SERVE_I : complete ? IDLE : state;
    end

    // Done flags mask a just-served port while its requester drops the strobe.
    always_comb begin
        i_req      = i_read & ~i_done;
        d_req      = (d_read | d_write) & ~d_done;
        i_busywait = i_req;
        d_busywait = d_req;
        grant_d    = state == IDLE & d_req & (~i_req | ~last_grant_d);
        grant_i    = state == IDLE & i_req & ~grant_d;
        complete   = state != IDLE & ~mem_busywait & seen_busy;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
            i_readdata    <= '0;
            d_readdata    <= '0;
            i_done        <= 1'b0;
            d_done        <= 1'b0;
            seen_busy     <= 1'b0;
            last_grant_d  <= 1'b0;
        end else begin
            i_done <= complete & state == SERVE_I;
            d_done <= complete & state == SERVE_D;
            if (grant_i | grant_d) begin
                mem_address  <= grant_d ? d_address : i_address;
                mem_read     <= grant_i | ~d_write;
                mem_write    <= grant_d & d_write;
                last_grant_d <= grant_d;
                seen_busy    <= 1'b0;
            end else if (state != IDLE & mem_busywait) begin
                seen_busy <= 1'b1;
            end
            if (grant_d)
                mem_writedata <= d_writedata;
            if (complete) begin
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
            end
            if (complete & mem_read & state == SERVE_I)
                i_readdata <= mem_readdata;
            if (complete & mem_read & state == SERVE_D)
                d_readdata <= mem_readdata;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a
// transaction-level reference and a behavioural memory with configurable latency.
module tb_mem_arbiter;
    logic         clock = 1'b0;
    logic         reset;
    logic         i_read, d_read, d_write;
    logic [5:0]   i_address, d_address, mem_address;
    logic [127:0] i_readdata, d_readdata, d_writedata, mem_writedata, mem_readdata;
    logic         i_busywait, d_busywait, mem_read, mem_write, mem_busywait;

    mem_arbiter #(.ADDR_W(6), .DATA_W(128)) dut (
        .clock(clock), .reset(reset),
        .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_busywait(i_busywait),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
        .d_readdata(d_readdata), .d_busywait(d_busywait),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
    );

    always #5 clock = ~clock;

    int tests = 0, fails = 0, cyc = 0;
    int rd_cnt = 0, wr_cnt = 0, ilow_cnt = 0, dbusy_cnt = 0;

    function automatic logic [127:0] init_val(input logic [5:0] a);
        logic [31:0] h;
        h = {26'd0, a} * 32'h9E3779B9 + 32'h12345;
        return (a == 6'h2A) ? 128'h0123456789ABCDEF0123456789ABCDEF : {h, ~h, h ^ 32'h5A5A5A5A, h + 32'd7};
    endfunction

    // Memory: busy for n cycles after lag quiet cycles, then ready until the strobe drops.
    int lag = 0, n = 5, cnt = 0;
    bit mem_init = 0;
    logic [127:0] mem [64];
    logic strobe, mem_ready;
    assign strobe       = mem_read | mem_write;
    assign mem_ready    = strobe && cnt >= lag + n;
    assign mem_busywait = strobe && cnt >= lag && cnt < lag + n;
    assign mem_readdata = mem_ready ? mem[mem_address] : {4{32'hDEADBEEF}};
    always @(posedge clock) begin
        if (!mem_init) begin
            for (int k = 0; k < 64; k++) mem[k] = init_val(6'(k));
            mem_init = 1;
        end
        if (mem_write && mem_ready) mem[mem_address] = mem_writedata;
        cnt <= strobe ? ((cnt < lag + n) ? cnt + 1 : cnt) : 0;
    end

    // Reference: one transfer at a time, ties go to the port not served last,
    // a port just served is ignored for one cycle, completion when memory is ready.
    int owner;
    bit ref_init = 0;
    logic mask_i, mask_d, last_d, cur_wr, ei, ed;
    logic [5:0] cur_addr;
    logic [127:0] cur_wd, exp_i_rd, exp_d_rd;
    logic [127:0] ref_mem [64];
    assign ei = i_read & ~mask_i;
    assign ed = (d_read | d_write) & ~mask_d;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            if (!ref_init) begin
                for (int k = 0; k < 64; k++) ref_mem[k] = init_val(6'(k));
                ref_init = 1;
            end
            owner <= 0; mask_i <= 0; mask_d <= 0; last_d <= 0;
            exp_i_rd <= '0; exp_d_rd <= '0;
        end else if (owner != 0 && mem_ready) begin
            if (owner == 1) begin
                exp_i_rd <= ref_mem[cur_addr];
                mask_i <= 1; mask_d <= 0;
            end else begin
                if (cur_wr) ref_mem[cur_addr] = cur_wd;
                else exp_d_rd <= ref_mem[cur_addr];
                mask_d <= 1; mask_i <= 0;
            end
            owner <= 0;
        end else begin
            mask_i <= 0; mask_d <= 0;
            if (owner == 0) begin
                if (ed && (!ei || !last_d)) begin
                    owner <= 2; cur_addr <= d_address; cur_wr <= d_write; cur_wd <= d_writedata; last_d <= 1;
                end else if (ei) begin
                    owner <= 1; cur_addr <= i_address; cur_wr <= 0; last_d <= 0;
                end
            end
        end
    end

    // Requester agents: hold a request until busywait is seen low at a posedge.
    typedef struct {logic wr; logic [5:0] a; logic [127:0] wd;} dreq_t;
    logic [5:0] iq[$];
    dreq_t dq[$];
    int i_taken = 0, d_taken = 0;
    int i_done_t[$], d_done_t[$];

    initial begin : agent_i
        logic fin;
        i_read = 0; i_address = '0;
        forever begin
            @(posedge clock);
            fin = i_read && !i_busywait;
            #1;
            if (fin) begin i_read = 0; i_done_t.push_back(cyc); end
            if (!i_read && i_taken < iq.size()) begin
                i_address = iq[i_taken]; i_taken++; i_read = 1;
            end
        end
    end

    initial begin : agent_d
        logic fin;
        d_read = 0; d_write = 0; d_address = '0; d_writedata = '0;
        forever begin
            @(posedge clock);
            fin = (d_read || d_write) && !d_busywait;
            #1;
            if (fin) begin d_read = 0; d_write = 0; d_done_t.push_back(cyc); end
            if (!d_read && !d_write && d_taken < dq.size()) begin
                d_address = dq[d_taken].a; d_writedata = dq[d_taken].wd;
                d_write = dq[d_taken].wr; d_read = !dq[d_taken].wr; d_taken++;
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        cyc++;
        rd_cnt += int'(mem_read); wr_cnt += int'(mem_write);
        ilow_cnt += int'(i_read && !i_busywait); dbusy_cnt += int'(d_busywait);
        check("mem_read", mem_read, owner != 0 && !cur_wr);
        check("mem_write", mem_write, owner != 0 && cur_wr);
        if (owner != 0) check("mem_address", mem_address, cur_addr);
        if (owner != 0 && cur_wr) check("mem_writedata", mem_writedata, cur_wd);
        check("i_readdata", i_readdata, exp_i_rd);
        check("d_readdata", d_readdata, exp_d_rd);
        check("i_busywait", i_busywait, ei);
        check("d_busywait", d_busywait, ed);
    endtask

    function automatic logic idle();
        return i_taken == iq.size() && d_taken == dq.size() && !i_read && !d_read && !d_write;
    endfunction

    task automatic wait_idle();
        int k = 0;
        step();
        while (!idle() && k < 600) begin step(); k++; end
        check("idle_timeout", idle(), 1);
        step(); step();
    endtask

    task automatic do_reset();
        step(); reset = 1; step(); step(); reset = 0;
    endtask

    initial begin
        int r0, w0, l0, b0, si, sd;
        reset = 1;
        step(); step(); reset = 0;
        check("reset_i_readdata", i_readdata, 0);
        check("reset_mem_read", mem_read, 0);

        // single icache read, 5 busy cycles
        r0 = rd_cnt; l0 = ilow_cnt; b0 = dbusy_cnt;
        iq.push_back(6'h2A);
        wait_idle();
        check("t1_read_cycles", rd_cnt - r0, 6);
        check("t1_i_low_cycles", ilow_cnt - l0, 1);
        check("t1_d_busy_cycles", dbusy_cnt - b0, 0);
        check("t1_i_data", i_readdata, 128'h0123456789ABCDEF0123456789ABCDEF);

        // simultaneous requests after reset: D first
        do_reset();
        iq.push_back(6'h01);
        dq.push_back('{1'b0, 6'h02, '0});
        wait_idle();
        check("t2_d_first", d_done_t[d_done_t.size()-1] < i_done_t[i_done_t.size()-1], 1);
        check("t2_i_data", i_readdata, init_val(6'h01));
        check("t2_d_data", d_readdata, init_val(6'h02));

        // dcache write
        do_reset();
        r0 = rd_cnt; w0 = wr_cnt;
        dq.push_back('{1'b1, 6'h3F, {32{4'h5}}});
        wait_idle();
        check("t3_write_cycles", wr_cnt - w0, 6);
        check("t3_read_cycles", rd_cnt - r0, 0);
        check("t3_d_readdata_kept", d_readdata, 0);
        check("t3_mem_content", mem[63], {32{4'h5}});

        // continuous requests from both ports alternate D,I,D,I
        do_reset();
        iq.push_back(6'h04); iq.push_back(6'h05);
        dq.push_back('{1'b0, 6'h06, '0}); dq.push_back('{1'b0, 6'h07, '0});
        wait_idle();
        si = i_done_t.size(); sd = d_done_t.size();
        check("t4_order", d_done_t[sd-2] < i_done_t[si-2] && i_done_t[si-2] < d_done_t[sd-1]
              && d_done_t[sd-1] < i_done_t[si-1], 1);
        check("t4_i_data", i_readdata, init_val(6'h05));
        check("t4_d_data", d_readdata, init_val(6'h07));

        // asynchronous reset two cycles into an icache transfer
        do_reset();
        iq.push_back(6'h09);
        for (int k = 0; k < 20 && !mem_read; k++) step();
        check("t5_granted", mem_read, 1);
        step();
        @(posedge clock);
        #2 reset = 1;
        #1;
        check("t5_strobe_drop", mem_read, 0);
        check("t5_busy_after_reset", i_busywait, 1);
        step(); step(); reset = 0;
        wait_idle();
        check("t5_i_data", i_readdata, init_val(6'h09));

        // stale low busywait before memory responds
        do_reset();
        lag = 1; n = 3;
        r0 = rd_cnt;
        iq.push_back(6'h2A);
        wait_idle();
        check("t6_read_cycles", rd_cnt - r0, 5);
        check("t6_i_data", i_readdata, 128'h0123456789ABCDEF0123456789ABCDEF);

        // randomized traffic on both ports
        for (int b = 0; b < 4; b++) begin
            lag = int'($urandom_range(0, 2)); n = int'($urandom_range(1, 4));
            for (int k = 0; k < 6; k++) begin
                iq.push_back(6'($urandom_range(0, 7)));
                dq.push_back('{1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)),
                               {$urandom, $urandom, $urandom, $urandom}});
            end
            wait_idle();
        end
        for (int k = 0; k < 8; k++) check("final_mem", mem[k], ref_mem[k]);
        check("i_completions", i_done_t.size(), iq.size());
        check("d_completions", d_done_t.size(), dq.size());

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter that shares the single 128-bit block-wide main memory between the instruction cache (read-only) and the data cache (read/write).
- Sits between both cache controllers and the memory.
- Each cache sees a private memory-like port with its own busywait. The arbiter serialises block transfers with round-robin tie-breaking and latches returned blocks per port.

Parameters:
ADDR_W, 6, block address width ({tag,index}).
DATA_W, 128, block width in bits (4 words).

Ports:
clock  input  1  system clock, all state updates on posedge
reset  input  1  asynchronous, active-high reset
i_read  input  1  icache block read request, held until i_busywait low
i_address  input  ADDR_W  icache block address
i_readdata  output  DATA_W  block returned to icache (registered)
i_busywait  output  1  icache stall
d_read  input  1  dcache block read request
d_write  input  1  dcache block write request (write-back)
d_address  input  ADDR_W  dcache block address
d_writedata  input  DATA_W  dcache block to write
d_readdata  output  DATA_W  block returned to dcache (registered)
d_busywait  output  1  dcache stall
mem_read  output  1  memory read strobe (registered)
mem_write  output  1  memory write strobe (registered)
mem_address  output  ADDR_W  memory block address (registered)
mem_writedata  output  DATA_W  memory write block (registered)
mem_readdata  input  DATA_W  memory read block
mem_busywait  input  1  memory busy

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
- Reset values:
  - state=IDLE; mem_read=mem_write=0; mem_address=0; mem_writedata=0.
  - i_readdata=d_readdata=0; done flags i_done=d_done=0; seen_busy=0.
  - last_grant=I, so the first tie goes to D.
- Requests:
  - i_req = i_read & ~i_done.
  - d_req = (d_read | d_write) & ~d_done.
  - The done mask stops a just-served port from being re-granted while it drops its strobe.
- Busywait (combinational):
  - i_busywait = i_read & ~i_done.
  - d_busywait = (d_read|d_write) & ~d_done.
  - Busywait is 0 whenever the port is not requesting.
- States: IDLE, SERVE_I, SERVE_D.
- IDLE, at posedge:
  - Only i_req: grant I.
  - Only d_req: grant D.
  - Both: grant the port that is not last_grant.
  - On grant: latch address (and d_writedata; set mem_write if d_write, else mem_read) into the mem_* registers. Set last_grant, clear seen_busy, go to SERVE_x.
  - d_read and d_write both high: treated as write.
  - Requester inputs are ignored after the grant (latched copy used).
- SERVE_x, at posedge:
  - mem_busywait=1: set seen_busy.
  - Completion = mem_busywait==0 & seen_busy. This guards against a stale low busywait before memory responds.
  - On completion:
    - Deassert mem_read/mem_write; go to IDLE.
    - Set x_done=1 for exactly one cycle.
    - For a read, latch mem_readdata into x_readdata. A write leaves x_readdata unchanged.
- Done flags:
  - x_done clears on the posedge after it is set.
  - The requester samples busywait=0 at that posedge and drops its strobe there.
- Latency:
  - Grant posedge G; memory strobe visible after G.
  - Completion posedge C; requester busywait low during cycle C..C+1.
  - The other port may be granted at posedge C+1 (its request is unmasked), so there is no dead cycle between back-to-back transfers of different ports.
- Same-port back-to-back: the new request is seen at C+2 at the earliest, after the strobe drops and is reasserted.
- Reset mid-transfer:
  - Strobes drop immediately (async) and the transfer is abandoned.
  - Requesters still asserting after reset are re-arbited from IDLE.
- mem_address and mem_writedata hold their last values in IDLE. They are not tristated.

Test Plan:
- Single icache read, address 6'h2A, memory model busy 5 cycles returning 128'h0123…CDEF: mem_read=1 with mem_address=6'h2A for 6 cycles. i_readdata=128'h0123…CDEF. i_busywait low exactly one cycle. d_busywait stays 0.
- Simultaneous i_read(6'h01) and d_read(6'h02) right after reset: D granted first (last_grant=I). I is granted at the posedge immediately after D completes. Both readdata values are correct.
- dcache write, addr 6'h3F, data all 5s: mem_write=1, mem_writedata=128'h5555…, mem_read=0. d_readdata unchanged. Completes on the first low busywait after a busy cycle.
- Continuous requests from both ports for 4 transfers: grants alternate D,I,D,I. No port waits more than one transfer.
- Asynchronous reset asserted 2 cycles into SERVE_I: mem_read=0 immediately; state IDLE; i_done=0. With i_read still high after reset release, it is re-granted and completes normally.
- mem_busywait held low for the first cycle after grant, then busy 3 cycles: no premature completion. Data is latched only after the busy phase ends.
